aes_block_sequencer: RTL
========================

# aes_block_sequencer

Byte-stream front end and scheduler for the AES-128 core. Assembles 16 input bytes into a 128-bit plaintext block, launches the core with a one-cycle start pulse, supervises completion with a timeout, then serializes the 128-bit ciphertext back out as bytes. It sits between the byte-wide host/file stream and the AES core's 128-bit block ports.

## Interface
- TIMEOUT_CYCLES, 255, max cycles spent in WAIT before error (1..255, 8-bit counter)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  plaintext byte
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts byte this cycle
- in_last  in  1  marks final byte of message; sampled on input handshake
- core_pt  out  128  plaintext block to core; byte k at [8k+7:8k]
- core_start  out  1  one-cycle launch pulse
- core_done  in  1  core result valid (single-cycle pulse)
- core_ct  in  128  ciphertext from core, sampled when core_done=1
- out_data  out  8  ciphertext byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- out_last  out  1  final byte of a block tagged last
- busy  out  1  high in any state except LOAD with byte count 0
- err  out  1  sticky timeout flag

## Operation
- States: LOAD, START, WAIT, DRAIN, ERR. Reset state LOAD.
- Byte order: first accepted byte → core_pt[7:0], byte 15 → [127:120]; output emits core_ct[7:0] first.
- LOAD: in_ready=1. Handshake (in_valid & in_ready) writes byte at index cnt, cnt++. Handshake at cnt=15 → START; blk_last register ← in_last.
- START: core_start=1 exactly one cycle → WAIT. core_pt held stable from START until leaving WAIT.
- WAIT: timer increments each cycle (first WAIT cycle counts 1). core_done=1 → capture core_ct, → DRAIN. Timer = TIMEOUT_CYCLES without done → ERR. core_done and timeout same cycle: done wins.
- DRAIN: out_valid=1, out_data = captured byte idx. Handshake → idx++. Handshake at idx=15 → LOAD with cnt=0, core_pt cleared. out_last = blk_last & (idx==15).
- ERR: err=1, in_ready=0, out_valid=0, core_start=0; remains until rst_n low.
- core_done outside WAIT ignored. out_valid holds with stable data until accepted.
- Reset mid-operation: all state/counters/registers to 0 asynchronously; partial block discarded.

## Timing
- Reset values: in_ready=1 after deassert (0 during reset), core_start=0, core_pt=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0.
- Last input handshake at cycle T → core_start at T+1 → WAIT from T+2.
- core_done at cycle D → out_valid at D+1; 16 bytes at full rate occupy D+1..D+16.
- Next block accepted at earliest the cycle after final output handshake; no input/output overlap.
- Timeout: err asserts the cycle after the TIMEOUT_CYCLES-th WAIT cycle.

## Configuration
- AES_SEQ_PAD_EN defined: in_last on handshake with cnt<15 zero-fills bytes cnt+1..15, sets blk_last, → START next cycle.
- Undefined: in_last only sets blk_last; block launches solely after 16 bytes.

## Structure
- Package aes_seq_pkg: state enum, BLOCK_BYTES=16, BYTE_IDX_W=4, DATA_W=128.
- Sub-module aes_block_serializer: 128-bit capture register + 4-bit index, valid/ready byte output, last flag; instantiated for DRAIN.

## Test plan
- Reset then bytes 0x00..0x0F, in_last on byte 15 → core_pt=0x0F0E…0100, core_start one cycle at T+1; core_done after 10 cycles with core_ct=0x69C4E0D86A7B0430D8CDB78070B4C55A → out bytes 0x5A,0xC5,…,0x69, out_last on 16th.
- Output back-pressure: out_ready toggled 1/0 → each byte held until accepted, 16 distinct bytes, no loss/duplication.
- Input gaps: in_valid random 50% → same core_pt as contiguous case.
- Timeout, TIMEOUT_CYCLES=8: core_done never asserted → err=1 after 8 WAIT cycles, in_ready=0 thereafter; stray core_done ignored; rst_n low clears err.
- core_done on cycle equal to timeout → DRAIN, err stays 0.
- AES_SEQ_PAD_EN: 3 bytes 0xAA,0xBB,0xCC with in_last on third → core_pt=0x…00CCBBAA, start next cycle; undefined → no start until 16 bytes.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared constants and state encoding for the AES block sequencer and its output serializer.
package aes_seq_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_IDX_W  = 4;
    localparam int DATA_W      = 128;

    typedef logic [2:0] state_t;

    localparam state_t S_LOAD  = 3'd0;
    localparam state_t S_START = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_ERR   = 3'd4;

endpackage

// File: rtl/aes_block_serializer.sv
// Holds one captured ciphertext block and streams it out least-significant byte first
// over a valid/ready byte interface.
module aes_block_serializer
    import aes_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] block,
    input  logic              last,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done
);

    logic [DATA_W-1:0]     ct;
    logic [BYTE_IDX_W-1:0] idx;
    logic                  valid;
    logic                  take;
    logic                  final_byte;

    assign take       = valid & out_ready;
    assign final_byte = (idx == BYTE_IDX_W'(BLOCK_BYTES - 1));
    assign done       = take & final_byte;

    // The register is cleared once drained so an idle serializer shows zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct    <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (capture) begin
            ct    <= block;
            idx   <= '0;
            valid <= 1'b1;
        end else if (take) begin
            if (final_byte) begin
                ct    <= '0;
                idx   <= '0;
                valid <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_data  = ct[{idx, 3'b000} +: 8];
    assign out_valid = valid;
    assign out_last  = valid & last & final_byte;

endmodule

// File: rtl/aes_block_sequencer.sv
// Byte-stream front end for the AES-128 core: gathers 16 bytes, launches the core, times out, drains.
// Define AES_SEQ_PAD_EN to let in_last close a short block with zero padding.
module aes_block_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [DATA_W-1:0] core_pt,
    output logic              core_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_ct,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

    state_t                state;
    logic [BYTE_IDX_W-1:0] cnt;
    logic [DATA_W-1:0]     pt;
    logic                  blk_last;
    logic [7:0]            timer;
    logic [7:0]            timer_next;
    logic                  in_fire;
    logic                  load_done;
    logic                  capture;
    logic                  drain_done;

    assign in_fire    = in_valid & in_ready;
    assign capture    = (state == S_WAIT) & core_done;
    assign timer_next = timer + 8'd1;

`ifdef AES_SEQ_PAD_EN
    assign load_done = in_fire & ((cnt == BYTE_IDX_W'(BLOCK_BYTES - 1)) | in_last);
`else
    assign load_done = in_fire & (cnt == BYTE_IDX_W'(BLOCK_BYTES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOAD;
            cnt      <= '0;
            pt       <= '0;
            blk_last <= 1'b0;
            timer    <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        // Bytes above the current slot are zeroed when a short block is closed.
                        for (int k = 0; k < BLOCK_BYTES; k++) begin
                            if (k == int'(cnt))
                                pt[8*k +: 8] <= in_data;
                            else if (load_done && k > int'(cnt))
                                pt[8*k +: 8] <= 8'h00;
                        end
                        cnt <= cnt + 1'b1;
                        if (load_done) begin
                            cnt      <= '0;
                            blk_last <= in_last;
                            state    <= S_START;
                        end
                    end
                end
                S_START: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer_next;
                    if (core_done)
                        state <= S_DRAIN;
                    else if (timer_next == TIMEOUT_CNT)
                        state <= S_ERR;
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        pt       <= '0;
                        blk_last <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_LOAD;
            endcase
        end
    end

    aes_block_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .block     (core_ct),
        .last      (blk_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (drain_done)
    );

    assign in_ready   = rst_n & (state == S_LOAD);
    assign core_start = (state == S_START);
    assign core_pt    = pt;
    assign busy       = !((state == S_LOAD) && (cnt == '0));
    assign err        = (state == S_ERR);

endmodule
